// File: rtl/tl_arb_pkg.sv
// Shared TileLink channel-A definitions for the A-channel arbiter.
// Holds the opcode values and the per-message beat-count helpers.
package tl_arb_pkg;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] ArithmeticData = 3'd2;
    localparam logic [2:0] LogicalData    = 3'd3;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] Hint           = 3'd5;
    localparam logic [2:0] AcquireBlock   = 3'd6;
    localparam logic [2:0] AcquirePerm    = 3'd7;

    function automatic logic has_data(input logic [2:0] opcode);
        return opcode <= LogicalData;
    endfunction

    // Messages no larger than one beat still take one beat.
    function automatic int unsigned num_beats(input logic [2:0] opcode,
                                              input int unsigned size,
                                              input int unsigned beat_bytes);
        int unsigned bytes;
        if (!has_data(opcode)) return 1;
        bytes = 32'd1 << size;
        return (bytes > beat_bytes) ? bytes / beat_bytes : 1;
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Round-robin picker: first asserted valid after ptr_i, searching upward with wrap.
// Returns index 0 and an all-zero one-hot when nothing is valid.
module tl_rr_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest valid candidate wins.
    always_comb begin
        grant_idx_o = '0;
        cand        = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (valid_i[cand]) grant_idx_o = cand;
        end
        grant_oh_o = '0;
        if (|valid_i) grant_oh_o[grant_idx_o] = 1'b1;
    end

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin TileLink channel-A arbiter with grant lock across stalls and bursts.
// Define TL_ARB_CHECK_EN to build the sticky upstream protocol checker (protocol_err).
module tl_a_arbiter
    import tl_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int ADDR_W     = 36,
    parameter  int DATA_W     = 256,
    parameter  int SRC_W      = 7,
    parameter  int SIZE_W     = 3,
    localparam int BEAT_BYTES = DATA_W / 8,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           in_valid,
    output logic [NUM_REQ-1:0]           in_ready,
    input  logic [3*NUM_REQ-1:0]         in_opcode,
    input  logic [3*NUM_REQ-1:0]         in_param,
    input  logic [SIZE_W*NUM_REQ-1:0]    in_size,
    input  logic [SRC_W*NUM_REQ-1:0]     in_source,
    input  logic [ADDR_W*NUM_REQ-1:0]    in_address,
    input  logic [BEAT_BYTES*NUM_REQ-1:0] in_mask,
    input  logic [DATA_W*NUM_REQ-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_opcode,
    output logic [2:0]                   out_param,
    output logic [SIZE_W-1:0]            out_size,
    output logic [SRC_W+IDX_W-1:0]       out_source,
    output logic [ADDR_W-1:0]            out_address,
    output logic [BEAT_BYTES-1:0]        out_mask,
    output logic [DATA_W-1:0]            out_data,
    output logic                         busy,
    output logic                         protocol_err
);

    localparam int MAX_BEATS = int'(num_beats(PutFullData, (1 << SIZE_W) - 1, BEAT_BYTES));
    localparam int CNT_W     = $clog2(MAX_BEATS) + 1;

    logic             locked_q, locked_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beats_left_q, beats_left_d;

    logic [NUM_REQ-1:0] pick_oh, grant_oh;
    logic [IDX_W-1:0]   pick_idx, grant_idx;
    logic [CNT_W-1:0]   cur_beats;
    logic               fire;
    int                 gsel;

    tl_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid_i     (in_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx)
    );

    assign grant_idx = locked_q ? lock_idx_q : pick_idx;
    assign grant_oh  = locked_q ? (NUM_REQ'(1) << lock_idx_q) : pick_oh;
    assign gsel      = int'(grant_idx);

    assign out_valid   = locked_q ? in_valid[lock_idx_q] : |in_valid;
    assign in_ready    = out_ready ? grant_oh : '0;
    assign out_opcode  = in_opcode[gsel*3 +: 3];
    assign out_param   = in_param[gsel*3 +: 3];
    assign out_size    = in_size[gsel*SIZE_W +: SIZE_W];
    assign out_source  = {grant_idx, in_source[gsel*SRC_W +: SRC_W]};
    assign out_address = in_address[gsel*ADDR_W +: ADDR_W];
    assign out_mask    = in_mask[gsel*BEAT_BYTES +: BEAT_BYTES];
    assign out_data    = in_data[gsel*DATA_W +: DATA_W];
    assign busy        = locked_q;

    assign fire      = out_valid & out_ready;
    assign cur_beats = CNT_W'(num_beats(out_opcode, 32'(out_size), BEAT_BYTES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked_q     <= 1'b0;
            lock_idx_q   <= '0;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            beats_left_q <= '0;
        end else begin
            locked_q     <= locked_d;
            lock_idx_q   <= lock_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
        end
    end

    // A stalled first beat locks with the full count; a fired first beat locks with one fewer.
    always_comb begin
        locked_d     = locked_q;
        lock_idx_d   = lock_idx_q;
        rr_ptr_d     = rr_ptr_q;
        beats_left_d = beats_left_q;
        if (!locked_q) begin
            if (out_valid && !out_ready) begin
                locked_d     = 1'b1;
                lock_idx_d   = grant_idx;
                beats_left_d = cur_beats;
            end else if (fire) begin
                if (cur_beats == CNT_W'(1)) begin
                    rr_ptr_d = grant_idx;
                end else begin
                    locked_d     = 1'b1;
                    lock_idx_d   = grant_idx;
                    beats_left_d = cur_beats - CNT_W'(1);
                end
            end
        end else if (fire) begin
            beats_left_d = beats_left_q - CNT_W'(1);
            if (beats_left_q == CNT_W'(1)) begin
                locked_d = 1'b0;
                rr_ptr_d = lock_idx_q;
            end
        end
    end

`ifdef TL_ARB_CHECK_EN
    logic                   err_q, prev_vld_q, violation;
    logic [2:0]             prev_op_q, prev_param_q, first_op_q;
    logic [SIZE_W-1:0]      prev_size_q, first_size_q;
    logic [SRC_W+IDX_W-1:0] prev_src_q, first_src_q;
    logic [ADDR_W-1:0]      prev_addr_q;

    always_comb begin
        violation = 1'b0;
        if (locked_q) begin
            if (!in_valid[lock_idx_q]) violation = 1'b1;
            if (out_valid && !out_ready && prev_vld_q &&
                ({out_opcode, out_param, out_size, out_source, out_address} !=
                 {prev_op_q, prev_param_q, prev_size_q, prev_src_q, prev_addr_q}))
                violation = 1'b1;
            if (out_valid && ({out_opcode, out_size, out_source} !=
                              {first_op_q, first_size_q, first_src_q}))
                violation = 1'b1;
        end
    end

    // First-beat header is captured on every unlocked cycle; the lock freezes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q        <= 1'b0;
            prev_vld_q   <= 1'b0;
            prev_op_q    <= '0;
            prev_param_q <= '0;
            prev_size_q  <= '0;
            prev_src_q   <= '0;
            prev_addr_q  <= '0;
            first_op_q   <= '0;
            first_size_q <= '0;
            first_src_q  <= '0;
        end else begin
            err_q        <= err_q | violation;
            prev_vld_q   <= out_valid;
            prev_op_q    <= out_opcode;
            prev_param_q <= out_param;
            prev_size_q  <= out_size;
            prev_src_q   <= out_source;
            prev_addr_q  <= out_address;
            if (!locked_q) begin
                first_op_q   <= out_opcode;
                first_size_q <= out_size;
                first_src_q  <= out_source;
            end
        end
    end

    assign protocol_err = err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Bench for tl_a_arbiter: directed scenarios plus randomized traffic against a message-level model.
module tb_tl_a_arbiter;

    localparam int N      = 3;
    localparam int ADDR_W = 36;
    localparam int DATA_W = 256;
    localparam int SRC_W  = 7;
    localparam int SIZE_W = 3;
    localparam int BB     = DATA_W / 8;
    localparam int IDX_W  = $clog2(N);
`ifdef TL_ARB_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic                   clock, reset_n;
    logic [N-1:0]           in_valid, in_ready;
    logic [3*N-1:0]         in_opcode, in_param;
    logic [SIZE_W*N-1:0]    in_size;
    logic [SRC_W*N-1:0]     in_source;
    logic [ADDR_W*N-1:0]    in_address;
    logic [BB*N-1:0]        in_mask;
    logic [DATA_W*N-1:0]    in_data;
    logic                   out_valid, out_ready, busy, protocol_err;
    logic [2:0]             out_opcode, out_param;
    logic [SIZE_W-1:0]      out_size;
    logic [SRC_W+IDX_W-1:0] out_source;
    logic [ADDR_W-1:0]      out_address;
    logic [BB-1:0]          out_mask;
    logic [DATA_W-1:0]      out_data;

    int n_vec = 0;
    int n_bad = 0;

    tl_a_arbiter #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_param(in_param), .in_size(in_size), .in_source(in_source),
        .in_address(in_address), .in_mask(in_mask), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_param(out_param), .out_size(out_size), .out_source(out_source),
        .out_address(out_address), .out_mask(out_mask), .out_data(out_data),
        .busy(busy), .protocol_err(protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int ref_beats(input int op, input int sz);
        int bytes;
        bytes = 1 << sz;
        if (op > 3) return 1;
        return (bytes <= BB) ? 1 : bytes / BB;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input int r, input logic [2:0] op, input logic [SIZE_W-1:0] sz,
                             input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr);
        in_valid[r]                  = 1'b1;
        in_opcode[r*3 +: 3]          = op;
        in_param[r*3 +: 3]           = 3'($urandom_range(0, 7));
        in_size[r*SIZE_W +: SIZE_W]  = sz;
        in_source[r*SRC_W +: SRC_W]  = src;
        in_address[r*ADDR_W +: ADDR_W] = addr;
        in_mask[r*BB +: BB]          = {$urandom(), $urandom(), $urandom(), $urandom(),
                                        $urandom(), $urandom(), $urandom(), $urandom()};
        in_data[r*DATA_W +: DATA_W]  = {$urandom(), $urandom(), $urandom(), $urandom(),
                                        $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        in_valid   = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = '0; out_ready = 1'b1;
        in_opcode = '0; in_param = '0; in_size = '0; in_source = '0;
        in_address = '0; in_mask = '0; in_data = '0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %b want 0", protocol_err); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        drive_req(0, 3'd4, 3'd6, 7'd5, 36'h1000);
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_vec++; if (out_source !== {2'd0, 7'd5}) begin n_bad++; $display("FAIL single_source got %h want %h", out_source, {2'd0, 7'd5}); end
        n_vec++; if (in_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready got %b want 001", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy got %b want 0", busy); end
        n_vec++; if (out_address !== 36'h1000) begin n_bad++; $display("FAIL single_addr got %h want 1000", out_address); end
    endtask

    task automatic test_alternate();
        do_reset();
        out_ready = 1'b1;
        drive_req(0, 3'd4, 3'd6, 7'd1, 36'h100);
        drive_req(1, 3'd4, 3'd6, 7'd2, 36'h200);
        for (int k = 0; k < 6; k++) begin
            #1;
            n_vec++;
            if (out_source[SRC_W +: IDX_W] !== IDX_W'(k % 2)) begin
                n_bad++; $display("FAIL alternate_grant cycle %0d got %0d want %0d", k, out_source[SRC_W +: IDX_W], k % 2);
            end
            tick();
        end
    endtask

    task automatic test_burst();
        do_reset();
        out_ready = 1'b1;
        drive_req(0, 3'd0, 3'd6, 7'd3, 36'h300);
        drive_req(1, 3'd4, 3'd6, 7'd4, 36'h400);
        #1;
        n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd0) begin n_bad++; $display("FAIL burst_beat1_grant got %0d want 0", out_source[SRC_W +: IDX_W]); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_beat1_busy got %b want 0", busy); end
        tick(); #1;
        n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd0) begin n_bad++; $display("FAIL burst_beat2_grant got %0d want 0", out_source[SRC_W +: IDX_W]); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL burst_beat2_busy got %b want 1", busy); end
        n_vec++; if (in_ready !== 3'b001) begin n_bad++; $display("FAIL burst_beat2_ready got %b want 001", in_ready); end
        tick(); #1;
        n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd1) begin n_bad++; $display("FAIL burst_next_grant got %0d want 1", out_source[SRC_W +: IDX_W]); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_next_busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 3'b010) begin n_bad++; $display("FAIL burst_next_ready got %b want 010", in_ready); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        drive_req(0, 3'd4, 3'd6, 7'd5, 36'h500);
        #1;
        n_vec++; if (out_valid !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_c0 valid/busy got %b/%b want 1/0", out_valid, busy); end
        n_vec++; if (in_ready !== 3'b000) begin n_bad++; $display("FAIL stall_c0_ready got %b want 000", in_ready); end
        tick();
        drive_req(1, 3'd4, 3'd6, 7'd6, 36'h600);
        for (int k = 1; k < 3; k++) begin
            #1;
            n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold c%0d grant/busy got %0d/%b want 0/1", k, out_source[SRC_W +: IDX_W], busy);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 3'b001) begin n_bad++; $display("FAIL stall_release_ready got %b want 001", in_ready); end
        tick();
        in_valid[0] = 1'b0;
        #1;
        n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL stall_after grant/busy got %0d/%b want 1/0", out_source[SRC_W +: IDX_W], busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_ready = 1'b1;
        drive_req(0, 3'd4, 3'd6, 7'd1, 36'h10);
        tick();
        in_valid[0] = 1'b0;
        drive_req(1, 3'd0, 3'd7, 7'd2, 36'h20);
        #1;
        n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd1) begin n_bad++; $display("FAIL rstmid_grant got %0d want 1", out_source[SRC_W +: IDX_W]); end
        tick(); #1;
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        in_valid = '0;
        reset_n  = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_reset busy/valid got %b/%b want 0/0", busy, out_valid); end
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive_req(0, 3'd4, 3'd6, 7'd3, 36'h30);
        drive_req(1, 3'd4, 3'd6, 7'd4, 36'h40);
        #1;
        n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_fresh grant/busy got %0d/%b want 0/0", out_source[SRC_W +: IDX_W], busy);
        end
        tick(); #1;
        n_vec++; if (out_source[SRC_W +: IDX_W] !== 2'd1) begin n_bad++; $display("FAIL rstmid_second_grant got %0d want 1", out_source[SRC_W +: IDX_W]); end
    endtask

    task automatic test_protocol_err();
        do_reset();
        out_ready = 1'b0;
        drive_req(0, 3'd4, 3'd6, 7'd5, 36'hA00);
        tick();
        in_address[0 +: ADDR_W] = 36'hB00;
        tick(); #1;
        n_vec++; if (protocol_err !== CHK) begin n_bad++; $display("FAIL perr_set got %b want %b", protocol_err, CHK); end
        in_address[0 +: ADDR_W] = 36'hA00;
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        tick(); #1;
        n_vec++; if (protocol_err !== CHK) begin n_bad++; $display("FAIL perr_sticky got %b want %b", protocol_err, CHK); end
        do_reset();
        #1;
        n_vec++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL perr_cleared got %b want 0", protocol_err); end
    endtask

    // Message-level model: an owner holds the sink until its message's beats have all fired.
    task automatic test_random();
        int owner, left, last, g, nb;
        logic v;
        logic [N-1:0] exp_rdy;
        int drv_left [N];
        do_reset();
        owner = -1; left = 0; last = N - 1;
        for (int r = 0; r < N; r++) drv_left[r] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (drv_left[r] == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int op, sz;
                        op = int'($urandom_range(0, 7));
                        sz = int'($urandom_range(0, 7));
                        drive_req(r, 3'(op), SIZE_W'(sz), SRC_W'($urandom()), ADDR_W'({$urandom(), $urandom()}));
                        drv_left[r] = ref_beats(op, sz);
                    end else begin
                        in_valid[r] = 1'b0;
                    end
                end else begin
                    in_data[r*DATA_W +: DATA_W] = {$urandom(), $urandom(), $urandom(), $urandom(),
                                                   $urandom(), $urandom(), $urandom(), $urandom()};
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = 0; v = 1'b0;
            if (owner >= 0) begin
                g = owner; v = in_valid[g];
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (in_valid[(last + k) % N]) begin g = (last + k) % N; v = 1'b1; break; end
                end
            end
            exp_rdy = (N'(out_ready) << g) & in_valid;
            n_vec++; if (out_valid !== v) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, out_valid, v); end
            n_vec++; if (busy !== (owner >= 0)) begin n_bad++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, owner >= 0); end
            n_vec++; if ((in_ready & in_valid) !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, in_ready & in_valid, exp_rdy); end
            if (v) begin
                n_vec++;
                if (out_source !== {IDX_W'(g), in_source[g*SRC_W +: SRC_W]} ||
                    out_opcode !== in_opcode[g*3 +: 3] || out_param !== in_param[g*3 +: 3] ||
                    out_size !== in_size[g*SIZE_W +: SIZE_W] || out_address !== in_address[g*ADDR_W +: ADDR_W]) begin
                    n_bad++; $display("FAIL rnd_header cyc %0d got src %h op %0d addr %h want src %h op %0d addr %h", cyc,
                                      out_source, out_opcode, out_address, {IDX_W'(g), in_source[g*SRC_W +: SRC_W]},
                                      in_opcode[g*3 +: 3], in_address[g*ADDR_W +: ADDR_W]);
                end
                n_vec++;
                if (out_data !== in_data[g*DATA_W +: DATA_W] || out_mask !== in_mask[g*BB +: BB]) begin
                    n_bad++; $display("FAIL rnd_payload cyc %0d data/mask differ from requester %0d", cyc, g);
                end
            end
            if (owner < 0 && v) begin
                owner = g;
                nb    = ref_beats(int'(in_opcode[g*3 +: 3]), int'(in_size[g*SIZE_W +: SIZE_W]));
                left  = nb;
            end
            if (v && out_ready) begin
                left--;
                drv_left[g]--;
                if (left == 0) begin last = g; owner = -1; end
            end
            tick();
        end
        in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_burst();
        test_stall();
        test_reset_mid_burst();
        test_protocol_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Round-robin arbiter that shares one TileLink channel-A sink between NUM_REQ upstream requesters, e.g. per-core L2 A channels feeding an L3 slice sinkA.
- Holds the grant while a stalled request waits and for the whole of a multi-beat burst.
- Tags the output source with the requester index so D responses can be routed back.
- Zero-latency pass-through datapath; only grant and lock state are registered.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 36, address width.
- DATA_W, 256, beat data width in bits; BEAT_BYTES = DATA_W/8.
- SRC_W, 7, per-requester source ID width.
- SIZE_W, 3, log2 transfer-size field width.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_REQ  per-requester A valid.
- in_ready  out  NUM_REQ  per-requester A ready.
- in_opcode  in  3*NUM_REQ  packed opcode.
- in_param  in  3*NUM_REQ  packed param.
- in_size  in  SIZE_W*NUM_REQ  packed log2 bytes.
- in_source  in  SRC_W*NUM_REQ  packed source.
- in_address  in  ADDR_W*NUM_REQ  packed address.
- in_mask  in  BEAT_BYTES*NUM_REQ  packed mask.
- in_data  in  DATA_W*NUM_REQ  packed data.
- out_valid  out  1  sink A valid.
- out_ready  in  1  sink A ready.
- out_opcode / out_param / out_size / out_address / out_mask / out_data  out  (widths as above)  muxed fields from the granted requester.
- out_source  out  SRC_W+IDX_W  {grant index, in_source}; IDX_W = clog2(NUM_REQ).
- busy  out  1  lock held (stalled grant or mid-burst).
- protocol_err  out  1  sticky checker flag (see Optional Feature).

Behaviour:
- Reset (async, reset_n low): locked=0, lock_idx=0, beats_left=0, rr_ptr=NUM_REQ-1, protocol_err=0. Consequently out_valid=0 (unless an in_valid is high with no lock) and busy=0.
- Fire condition: fire = out_valid & out_ready.
- Beat count: data opcodes 0..3 (PutFull, PutPartial, Arithmetic, Logical) use beats = max(1, 2^size / BEAT_BYTES). All other opcodes use 1 beat. Counter width is clog2(max beats)+1.
- IDLE (locked=0):
  - grant = first asserted in_valid searching (rr_ptr+1) mod NUM_REQ upward with wrap.
  - out_valid = |in_valid; fields come from grant combinationally (0-cycle latency).
  - in_ready[grant] = out_ready; all other in_ready = 0.
- Transitions out of IDLE:
  - out_valid & !out_ready: locked<=1, lock_idx<=grant, beats_left<=beats (HOLD).
  - fire with beats==1: rr_ptr<=grant; stay IDLE.
  - fire with beats>1: locked<=1, lock_idx<=grant, beats_left<=beats-1 (BURST).
- LOCKED (locked=1):
  - grant = lock_idx irrespective of other in_valid.
  - out_valid = in_valid[lock_idx].
  - Each fire decrements beats_left. The fire that leaves beats_left at 0 clears locked and sets rr_ptr<=lock_idx.
  - In HOLD, beats_left holds the full count until the first fire.
- busy = locked.
- rr_ptr updates only at the last beat of a message. A message of N beats occupies the sink exclusively for N fires.
- No requester valid: out_valid=0, out fields are don't-care (drive requester 0 fields), state is unchanged.
- If the locked requester drops in_valid mid-burst: out_valid=0 and the lock is held (illegal upstream, tolerated).
- Simultaneous last-beat fire and a new in_valid: the new arbitration uses the updated rr_ptr from the next cycle.
- Reset asserted mid-burst: the burst is abandoned and all state returns to reset values.

Optional Feature:
- Macro: TL_ARB_CHECK_EN.
- Defined: registered checker.
  - While locked, out_valid=1 and out_ready=0, out_opcode/param/size/source/address must equal the previous cycle's values.
  - Within a burst, opcode/size/source must match the first beat.
  - in_valid[lock_idx] must not fall before the last beat.
  - Any violation sets protocol_err=1 the next cycle; the flag stays set until reset.
- Undefined: checker absent; protocol_err tied 0.

Decomposition:
- Package tl_arb_pkg holds:
  - opcode localparams (PutFullData=0, PutPartialData=1, ArithmeticData=2, LogicalData=3, Get=4, Hint=5, AcquireBlock=6, AcquirePerm=7);
  - function has_data(opcode);
  - function num_beats(opcode, size, BEAT_BYTES).
- One sub-module: tl_rr_picker (NUM_REQ-wide one-hot round-robin pick from valid vector and pointer).

Test Plan:
- Only req0 valid, Get, size=6, source=5, out_ready=1 → out_valid same cycle, out_source={0,5}, in_ready[0]=1, busy=0.
- After reset, req0 and req1 both issue Gets every cycle, out_ready=1 → grants alternate 0,1,0,1 starting with req0.
- req0 PutFullData size=6 (2 beats, DATA_W=256) with req1 valid throughout → req0 beats 1 and 2 fire back-to-back, busy=1 between them, req1 granted on the 3rd cycle.
- req0 valid, out_ready=0 for 3 cycles, req1 asserts in cycle 1 → grant stays req0, busy=1, req0 fires when out_ready=1, then req1.
- reset_n pulsed low after beat 1 of a 4-beat Put (size=7) → out_valid/busy low during reset; after release, rr_ptr=NUM_REQ-1 and arbitration restarts fresh.
- With TL_ARB_CHECK_EN: req0 changes address while stalled → protocol_err=1 next cycle and stays 1 until reset; without the macro, protocol_err stays 0.
